// File: rtl/demod_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demod_pkg
// Purpose  : Shared types and fixed-point helpers for the FM demodulator
//            front half and the downstream angle stage.
//            - BITS / QUANT_VAL : fixed-point fraction size and scale
//            - state_t          : sample-processing state encoding
//            - dequantize()     : 64-bit product -> sample width, signed divide
//                                 by QUANT_VAL truncating toward zero
// Revision : 1.0 - initial release
// ============================================================================
package demod_pkg;

  localparam int SAMPLE_WIDTH = 32;
  localparam int PROD_WIDTH   = 2 * SAMPLE_WIDTH;
  localparam int BITS         = 10;
  localparam int QUANT_VAL    = 1 << BITS;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_DEMOD = 2'd1,
    S_ATAN  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // An arithmetic shift alone rounds toward minus infinity; biasing negative
  // values by QUANT_VAL-1 first makes the result round toward zero, matching
  // a C-style signed divide.
  function automatic logic signed [SAMPLE_WIDTH-1:0] dequantize(
    input logic signed [PROD_WIDTH-1:0] value
  );
    logic signed [PROD_WIDTH-1:0] biased;
    biased = value[PROD_WIDTH-1] ? value + PROD_WIDTH'(QUANT_VAL - 1) : value;
    return SAMPLE_WIDTH'(biased >>> BITS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/demod_qarctan_prep.sv
`default_nettype none
// ============================================================================
// Module   : demod_qarctan_prep
// Purpose  : FM demodulator front half. Pops one complex sample per
//            transaction, forms the conjugate product with the previous
//            sample, dequantizes it and produces the qarctan numerator and
//            denominator for the downstream divider.
// Ports    : clock / reset       - rising-edge clock, async active-low reset
//            real_* / imag_*     - show-ahead I and Q input FIFOs (always
//                                  popped together)
//            num_* / den_*       - divider A and B FIFOs (always pushed
//                                  together); den_din is always >= 1
//            quad_*              - optional {x<0, y<0} sideband FIFO, present
//                                  only when DEMOD_QUAD_SIDEBAND_EN is defined
// Macro    : DEMOD_QUAD_SIDEBAND_EN
// Revision : 1.0 - initial release
// ============================================================================
module demod_qarctan_prep
  import demod_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         real_rd_en,
  input  logic                         real_empty,
  input  logic signed [DATA_WIDTH-1:0] real_dout,
  output logic                         imag_rd_en,
  input  logic                         imag_empty,
  input  logic signed [DATA_WIDTH-1:0] imag_dout,
  output logic                         num_wr_en,
  input  logic                         num_full,
  output logic signed [DATA_WIDTH-1:0] num_din,
  output logic                         den_wr_en,
  input  logic                         den_full,
  output logic signed [DATA_WIDTH-1:0] den_din
`ifdef DEMOD_QUAD_SIDEBAND_EN
  ,
  output logic                         quad_wr_en,
  input  logic                         quad_full,
  output logic [1:0]                   quad_din
`endif
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = DATA_WIDTH + 2;

  state_t                  state_q, state_d;
  logic signed [DATA_WIDTH-1:0] prev_real_q, prev_real_d;
  logic signed [DATA_WIDTH-1:0] prev_imag_q, prev_imag_d;
  logic signed [PW-1:0]    prod_rr_q, prod_rr_d;   // prev_real * cur_real
  logic signed [PW-1:0]    prod_ii_q, prod_ii_d;   // prev_imag * cur_imag
  logic signed [PW-1:0]    prod_ri_q, prod_ri_d;   // prev_real * cur_imag
  logic signed [PW-1:0]    prod_ir_q, prod_ir_d;   // prev_imag * cur_real
  logic signed [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic signed [DATA_WIDTH-1:0] num_q, num_d, den_q, den_d;
`ifdef DEMOD_QUAD_SIDEBAND_EN
  logic [1:0]              quad_q, quad_d;
`endif

  logic                    pop;
  logic                    push_ok;
  logic signed [PW-1:0]    demod_re, demod_im;
  logic signed [AW-1:0]    atan_x, atan_y, atan_abs_y, atan_num, atan_den;

  // Both FIFOs are popped only when both hold data, so I and Q never skew.
  assign pop = (state_q == S_READ) && !real_empty && !imag_empty;

`ifdef DEMOD_QUAD_SIDEBAND_EN
  assign push_ok = (state_q == S_WRITE) && !num_full && !den_full && !quad_full;
`else
  assign push_ok = (state_q == S_WRITE) && !num_full && !den_full;
`endif

  // Strobes are gated by reset so they drop the moment reset asserts,
  // without waiting for the state register to settle.
  assign real_rd_en = reset && pop;
  assign imag_rd_en = reset && pop;
  assign num_wr_en  = reset && push_ok;
  assign den_wr_en  = reset && push_ok;
  assign num_din    = num_q;
  assign den_din    = den_q;
`ifdef DEMOD_QUAD_SIDEBAND_EN
  assign quad_wr_en = reset && push_ok;
  assign quad_din   = quad_q;
`endif

  // Conjugate product cur * conj(prev).
  assign demod_re = prod_rr_q + prod_ii_q;
  assign demod_im = prod_ri_q - prod_ir_q;

  // qarctan operands; two guard bits keep |y|+1 and x +/- abs_y exact.
  always_comb begin
    atan_x     = AW'(x_q);
    atan_y     = AW'(y_q);
    atan_abs_y = (atan_y[AW-1] ? -atan_y : atan_y) + AW'(1);
    if (!atan_x[AW-1]) begin
      atan_num = (atan_x - atan_abs_y) <<< BITS;
      atan_den = atan_x + atan_abs_y;
    end else begin
      atan_num = (atan_x + atan_abs_y) <<< BITS;
      atan_den = atan_abs_y - atan_x;
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_real_d = prev_real_q;
    prev_imag_d = prev_imag_q;
    prod_rr_d   = prod_rr_q;
    prod_ii_d   = prod_ii_q;
    prod_ri_d   = prod_ri_q;
    prod_ir_d   = prod_ir_q;
    x_d         = x_q;
    y_d         = y_q;
    num_d       = num_q;
    den_d       = den_q;
`ifdef DEMOD_QUAD_SIDEBAND_EN
    quad_d      = quad_q;
`endif
    case (state_q)
      S_READ: begin
        if (pop) begin
          // The current sample is consumed directly from the show-ahead
          // outputs; only the products and the new "previous" are kept.
          prod_rr_d   = PW'(prev_real_q) * PW'(real_dout);
          prod_ii_d   = PW'(prev_imag_q) * PW'(imag_dout);
          prod_ri_d   = PW'(prev_real_q) * PW'(imag_dout);
          prod_ir_d   = PW'(prev_imag_q) * PW'(real_dout);
          prev_real_d = real_dout;
          prev_imag_d = imag_dout;
          state_d     = S_DEMOD;
        end
      end
      S_DEMOD: begin
        x_d     = dequantize(demod_re);
        y_d     = dequantize(demod_im);
        state_d = S_ATAN;
      end
      S_ATAN: begin
        num_d   = atan_num[DATA_WIDTH-1:0];
        den_d   = atan_den[DATA_WIDTH-1:0];
`ifdef DEMOD_QUAD_SIDEBAND_EN
        quad_d  = {x_q[DATA_WIDTH-1], y_q[DATA_WIDTH-1]};
`endif
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (push_ok) state_d = S_READ;
      end
      default: state_d = S_READ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_READ;
      prev_real_q <= '0;
      prev_imag_q <= '0;
      prod_rr_q   <= '0;
      prod_ii_q   <= '0;
      prod_ri_q   <= '0;
      prod_ir_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
      num_q       <= '0;
      den_q       <= '0;
`ifdef DEMOD_QUAD_SIDEBAND_EN
      quad_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      prev_real_q <= prev_real_d;
      prev_imag_q <= prev_imag_d;
      prod_rr_q   <= prod_rr_d;
      prod_ii_q   <= prod_ii_d;
      prod_ri_q   <= prod_ri_d;
      prod_ir_q   <= prod_ir_d;
      x_q         <= x_d;
      y_q         <= y_d;
      num_q       <= num_d;
      den_q       <= den_d;
`ifdef DEMOD_QUAD_SIDEBAND_EN
      quad_q      <= quad_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demod_qarctan_prep.sv
`default_nettype none
// ============================================================================
// Module   : tb_demod_qarctan_prep
// Purpose  : Self-checking bench for demod_qarctan_prep. Source FIFOs are
//            modelled as queues; every pushed sample queues its expected
//            numerator/denominator, which are popped and compared when the
//            DUT writes. Honours DEMOD_QUAD_SIDEBAND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demod_qarctan_prep;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic real_rd_en, imag_rd_en, num_wr_en, den_wr_en;
  logic real_empty = 1'b1;
  logic imag_empty = 1'b1;
  logic signed [W-1:0] real_dout = '0;
  logic signed [W-1:0] imag_dout = '0;
  logic signed [W-1:0] num_din, den_din;
  logic num_full = 1'b0;
  logic den_full = 1'b0;
`ifdef DEMOD_QUAD_SIDEBAND_EN
  logic       quad_wr_en;
  logic       quad_full = 1'b0;
  logic [1:0] quad_din;
`endif

  int tests = 0;
  int fails = 0;
  int writes = 0;
  int last_num = 0;
  int last_den = 0;
  int real_q[$];
  int imag_q[$];
  int exp_num[$];
  int exp_den[$];
  logic [1:0] exp_quad[$];
  longint m_pr = 0;
  longint m_pi = 0;

  demod_qarctan_prep #(.DATA_WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .real_rd_en (real_rd_en),
    .real_empty (real_empty),
    .real_dout  (real_dout),
    .imag_rd_en (imag_rd_en),
    .imag_empty (imag_empty),
    .imag_dout  (imag_dout),
    .num_wr_en  (num_wr_en),
    .num_full   (num_full),
    .num_din    (num_din),
    .den_wr_en  (den_wr_en),
    .den_full   (den_full),
    .den_din    (den_din)
`ifdef DEMOD_QUAD_SIDEBAND_EN
    ,
    .quad_wr_en (quad_wr_en),
    .quad_full  (quad_full),
    .quad_din   (quad_din)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // Show-ahead source FIFOs: pop on the rising edge, refresh outputs on both
  // edges so pushes made after a rising edge appear by the falling edge.
  always @(posedge clock or negedge clock) begin
    if (clock) begin
      if (real_rd_en === 1'b1 && real_q.size() > 0) void'(real_q.pop_front());
      if (imag_rd_en === 1'b1 && imag_q.size() > 0) void'(imag_q.pop_front());
    end
    real_empty <= (real_q.size() == 0);
    imag_empty <= (imag_q.size() == 0);
    real_dout  <= (real_q.size() > 0) ? real_q[0] : 0;
    imag_dout  <= (imag_q.size() > 0) ? imag_q[0] : 0;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Golden model: C-style divide for dequantization, 64-bit qarctan math.
  function automatic void golden(input longint pr, input longint pi,
                                 input longint cr, input longint ci,
                                 output int n, output int d, output logic [1:0] qd);
    longint re, im, x, y, ay, nn, dd;
    re = pr * cr + pi * ci;
    im = pr * ci - pi * cr;
    x  = longint'(int'(re / 1024));
    y  = longint'(int'(im / 1024));
    ay = ((y < 0) ? -y : y) + 1;
    if (x >= 0) begin
      nn = (x - ay) * 1024;
      dd = x + ay;
    end else begin
      nn = (x + ay) * 1024;
      dd = ay - x;
    end
    n  = int'(nn);
    d  = int'(dd);
    qd = {x < 0, y < 0};
  endfunction

  task automatic push(input int i, input int q);
    int n, d;
    logic [1:0] qd;
    golden(m_pr, m_pi, longint'(i), longint'(q), n, d, qd);
    exp_num.push_back(n);
    exp_den.push_back(d);
    exp_quad.push_back(qd);
    m_pr = i;
    m_pi = q;
    real_q.push_back(i);
    imag_q.push_back(q);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int c = 0; c < budget && exp_num.size() > 0; c++) @(negedge clock);
    chk({"drain_", tag}, exp_num.size(), 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic step(input int i, input int q);
    @(posedge clock);
    #1 push(i, q);
    drain("step", 60);
  endtask

  task automatic directed(input string tag, input int i, input int q,
                          input int en, input int ed);
    step(i, q);
    chk({tag, "_num"}, last_num, en);
    chk({tag, "_den"}, last_den, ed);
  endtask

  // Output monitor / scoreboard.
  always @(negedge clock) begin
    if (num_wr_en === 1'b1 || den_wr_en === 1'b1) begin
      writes++;
`ifdef DEMOD_QUAD_SIDEBAND_EN
      chk("wr_triple", {num_wr_en, den_wr_en, quad_wr_en}, 3'b111);
`else
      chk("wr_pair", {num_wr_en, den_wr_en}, 2'b11);
`endif
      chk("sb_has_entry", exp_num.size() > 0, 1);
      if (exp_num.size() > 0) begin
        chk("num_din", num_din, exp_num.pop_front());
        chk("den_din", den_din, exp_den.pop_front());
`ifdef DEMOD_QUAD_SIDEBAND_EN
        chk("quad_din", quad_din, exp_quad.pop_front());
`else
        void'(exp_quad.pop_front());
`endif
        last_num = num_din;
        last_den = den_din;
      end
    end
  end

  initial begin
    int w0;
    int bad_strobe, bad_data;
    logic signed [W-1:0] held_num, held_den;

    // Reset with a sample already waiting: nothing may be popped.
    #2 reset = 1'b0;
    @(posedge clock);
    #1 push(1024, 0);
    repeat (2) @(negedge clock);
    chk("rst_rd_en", {real_rd_en, imag_rd_en}, 0);
    chk("rst_wr_en", {num_wr_en, den_wr_en}, 0);
    chk("rst_num_din", num_din, 0);
    chk("rst_den_din", den_din, 0);
    chk("rst_fifo_untouched", real_q.size(), 1);

    // 1: prev=0, (1024,0) -> num=-1024, den=1, single write.
    w0 = writes;
    @(posedge clock);
    #1 reset = 1'b1;
    drain("t1", 60);
    chk("t1_num", last_num, -1024);
    chk("t1_den", last_den, 1);
    chk("t1_one_write", writes - w0, 1);

    // 2..4: directed conjugate products and truncation toward zero.
    directed("t2", 0, 1024, -1049600, 1025);
    step(1024, 0);
    directed("t3", -1024, 0, -1047552, 1025);
    step(1, 0);
    directed("t4a", -1, 0, -1024, 1);
    step(1, 0);
    directed("t4b", -2000, 0, 0, 2);

    // 5: backpressure on the A FIFO for 20 cycles.
    @(posedge clock);
    #1 num_full = 1'b1;
    push(3000, -700);
    push(-50, 90);
    repeat (4) @(negedge clock);
    held_num = num_din;
    held_den = den_din;
    chk("bp_num_held", num_din, exp_num[0]);
    chk("bp_den_held", den_din, exp_den[0]);
    bad_strobe = 0;
    bad_data   = 0;
    for (int c = 0; c < 20; c++) begin
      if ({real_rd_en, imag_rd_en, num_wr_en, den_wr_en} !== 4'b0000) bad_strobe++;
      if (num_din !== held_num || den_din !== held_den) bad_data++;
      @(negedge clock);
    end
    chk("bp_no_strobes", bad_strobe, 0);
    chk("bp_data_stable", bad_data, 0);
    @(posedge clock);
    #1 num_full = 1'b0;
    @(negedge clock);
    chk("bp_write", {num_wr_en, den_wr_en}, 2'b11);
    @(negedge clock);
    chk("bp_resume_pop", {real_rd_en, imag_rd_en}, 2'b11);
    drain("bp", 60);

    // 6: reset while the sample sits in S_ATAN.
    @(posedge clock);
    #1 push(5000, -3000);
    repeat (2) @(negedge clock);
    chk("rm_popped", real_q.size(), 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rm_strobes", {real_rd_en, imag_rd_en, num_wr_en, den_wr_en}, 0);
    chk("rm_num_din", num_din, 0);
    chk("rm_den_din", den_din, 0);
    exp_num.delete();
    exp_den.delete();
    exp_quad.delete();
    m_pr = 0;
    m_pi = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    directed("rm_after", 1024, 0, -1024, 1);

    // Random stream with random output backpressure.
    w0 = writes;
    @(posedge clock);
    #1;
    for (int k = 0; k < 256; k++)
      push(int'($urandom_range(0, 1048575)) - 524288,
           int'($urandom_range(0, 1048575)) - 524288);
    for (int c = 0; c < 6000 && exp_num.size() > 0; c++) begin
      @(posedge clock);
      #1;
      num_full = ($urandom_range(0, 3) == 0);
      den_full = ($urandom_range(0, 3) == 0);
`ifdef DEMOD_QUAD_SIDEBAND_EN
      quad_full = ($urandom_range(0, 3) == 0);
`endif
    end
    num_full = 1'b0;
    den_full = 1'b0;
`ifdef DEMOD_QUAD_SIDEBAND_EN
    quad_full = 1'b0;
`endif
    drain("rand", 60);
    chk("rand_write_count", writes - w0, 256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
